// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage register/control bits in,
// stall/flush/forward controls and performance counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_rd_addr;
  logic [4:0]       ex_rs1_addr;
  logic [4:0]       ex_rs2_addr;
  logic             ex_redirect;
  logic             mem_reg_write;
  logic [4:0]       mem_rd_addr;
  logic             wb_reg_write;
  logic [4:0]       wb_rd_addr;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_rd_addr, ex_rs1_addr, ex_rs2_addr, ex_redirect,
           mem_reg_write, mem_rd_addr, wb_reg_write, wb_rd_addr,
           mem_req, mem_ready,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, forward_a, forward_b, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_rd_addr, ex_rs1_addr, ex_rs2_addr, ex_redirect,
           mem_reg_write, mem_rd_addr, wb_reg_write, wb_rd_addr,
           mem_req, mem_ready,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, forward_a, forward_b, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and flow controller for the five-stage RV32I pipeline: load-use bubbles,
// redirect flushes with fetch-latency bubbles, data-memory wait stalls, forwarding.
module hazard_ctrl #(
  parameter int IMEM_LAT = 1,
  parameter int CNT_W    = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic {RUN = 1'b0, REDIRECT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       bub_cnt_q, bub_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, flush_events_q;

  logic mem_wait, load_use, redirect_acc;
  logic pc_stall_s, if_id_stall_s, if_id_flush_s;
  logic id_ex_stall_s, id_ex_flush_s, ex_mem_stall_s;

  // MEM result is younger than WB, so it wins; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic       mem_wr,
                                         input logic [4:0] mem_rd,
                                         input logic       wb_wr,
                                         input logic [4:0] wb_rd,
                                         input logic [4:0] rs);
    logic [1:0] sel;
    if (mem_wr && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = 2'b10;
    end else if (wb_wr && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  always_comb begin
    mem_wait = bus.mem_req & ~bus.mem_ready;
    load_use = bus.ex_mem_read & (bus.ex_rd_addr != 5'd0) &
               ((bus.id_uses_rs1 & (bus.id_rs1_addr == bus.ex_rd_addr)) |
                (bus.id_uses_rs2 & (bus.id_rs2_addr == bus.ex_rd_addr)));

    pc_stall_s     = 1'b0;
    if_id_stall_s  = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_stall_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_stall_s = 1'b0;
    redirect_acc   = 1'b0;
    state_d        = state_q;
    bub_cnt_d      = bub_cnt_q;

    if (rst) begin
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else if (mem_wait) begin
      // Whole front of the pipe freezes; a pending redirect waits in EX.
      pc_stall_s     = 1'b1;
      if_id_stall_s  = 1'b1;
      id_ex_stall_s  = 1'b1;
      ex_mem_stall_s = 1'b1;
    end else if (bus.ex_redirect) begin
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
      redirect_acc  = 1'b1;
      if (IMEM_LAT > 0) begin
        state_d   = REDIRECT;
        bub_cnt_d = 2'(IMEM_LAT);
      end else begin
        state_d   = RUN;
        bub_cnt_d = 2'd0;
      end
    end else if (state_q == REDIRECT) begin
      if_id_flush_s = 1'b1;
      bub_cnt_d     = bub_cnt_q - 2'd1;
      if (bub_cnt_q == 2'd1) begin
        state_d = RUN;
      end else begin
        state_d = REDIRECT;
      end
    end else if (load_use) begin
      pc_stall_s    = 1'b1;
      if_id_stall_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else begin
      state_d = RUN;
    end
  end

  // Controller state and saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      bub_cnt_q      <= 2'd0;
      stall_cycles_q <= {CNT_W{1'b0}};
      flush_events_q <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      bub_cnt_q <= bub_cnt_d;
      if (pc_stall_s && (stall_cycles_q != {CNT_W{1'b1}})) begin
        stall_cycles_q <= stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (redirect_acc && (flush_events_q != {CNT_W{1'b1}})) begin
        flush_events_q <= flush_events_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.pc_stall     = pc_stall_s;
  assign bus.if_id_stall  = if_id_stall_s;
  assign bus.if_id_flush  = if_id_flush_s;
  assign bus.id_ex_stall  = id_ex_stall_s;
  assign bus.id_ex_flush  = id_ex_flush_s;
  assign bus.ex_mem_stall = ex_mem_stall_s;
  assign bus.forward_a    = fwd_sel(bus.mem_reg_write, bus.mem_rd_addr,
                                    bus.wb_reg_write, bus.wb_rd_addr, bus.ex_rs1_addr);
  assign bus.forward_b    = fwd_sel(bus.mem_reg_write, bus.mem_rd_addr,
                                    bus.wb_reg_write, bus.wb_rd_addr, bus.ex_rs2_addr);
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with IMEM_LAT=2 and 4-bit counters.
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  hazard_ctrl_if #(.CNT_W(4)) bus ();

  hazard_ctrl #(.IMEM_LAT(2), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall}
  function automatic logic [31:0] ctl();
    return 32'({bus.pc_stall, bus.if_id_stall, bus.if_id_flush,
                bus.id_ex_stall, bus.id_ex_flush, bus.ex_mem_stall});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_rs1_addr   = 5'd0;
    bus.id_rs2_addr   = 5'd0;
    bus.id_uses_rs1   = 1'b0;
    bus.id_uses_rs2   = 1'b0;
    bus.ex_mem_read   = 1'b0;
    bus.ex_rd_addr    = 5'd0;
    bus.ex_rs1_addr   = 5'd0;
    bus.ex_rs2_addr   = 5'd0;
    bus.ex_redirect   = 1'b0;
    bus.mem_reg_write = 1'b0;
    bus.mem_rd_addr   = 5'd0;
    bus.wb_reg_write  = 1'b0;
    bus.wb_rd_addr    = 5'd0;
    bus.mem_req       = 1'b0;
    bus.mem_ready     = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic use1);
    bus.ex_mem_read = 1'b1;
    bus.ex_rd_addr  = rd;
    bus.id_rs1_addr = rs1;
    bus.id_uses_rs1 = use1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset with busy-looking inputs: only the two flushes, forwarding still live.
    idle();
    rst = 1'b1;
    set_load_use(5'd5, 5'd5, 1'b1);
    bus.mem_req       = 1'b1;
    bus.ex_redirect   = 1'b1;
    bus.mem_reg_write = 1'b1;
    bus.mem_rd_addr   = 5'd3;
    bus.ex_rs1_addr   = 5'd3;
    #12;
    chk("rst_ctl", ctl(), 32'h0A);
    chk("rst_fwd_a", 32'(bus.forward_a), 32'd2);
    chk("rst_stall_cnt", 32'(bus.stall_cycles), 32'd0);
    chk("rst_flush_cnt", 32'(bus.flush_events), 32'd0);

    @(negedge clk);
    idle();
    rst = 1'b0;
    #1 chk("run_idle", ctl(), 32'h00);
    @(negedge clk);
    chk("run_idle2", ctl(), 32'h00);

    // Load-use on rs1: one-cycle bubble.
    set_load_use(5'd5, 5'd5, 1'b1);
    #1 chk("lu_rs1", ctl(), 32'h32);
    @(negedge clk);
    chk("lu_cnt1", 32'(bus.stall_cycles), 32'd1);
    bus.ex_mem_read = 1'b0;
    #1 chk("lu_clear", ctl(), 32'h00);

    @(negedge clk);
    set_load_use(5'd0, 5'd0, 1'b1);
    #1 chk("lu_rd0", ctl(), 32'h00);
    set_load_use(5'd5, 5'd5, 1'b0);
    #1 chk("lu_nouse", ctl(), 32'h00);
    bus.id_rs2_addr = 5'd5;
    bus.id_uses_rs2 = 1'b1;
    #1 chk("lu_rs2", ctl(), 32'h32);
    @(negedge clk);
    idle();
    #1 chk("lu_cnt2", 32'(bus.stall_cycles), 32'd2);

    // Forwarding priority and x0 exclusion.
    bus.mem_reg_write = 1'b1;
    bus.wb_reg_write  = 1'b1;
    bus.mem_rd_addr   = 5'd7;
    bus.wb_rd_addr    = 5'd7;
    bus.ex_rs1_addr   = 5'd7;
    #1 chk("fwd_a_mem", 32'(bus.forward_a), 32'd2);
    bus.mem_reg_write = 1'b0;
    #1 chk("fwd_a_wb", 32'(bus.forward_a), 32'd1);
    bus.mem_reg_write = 1'b1;
    bus.mem_rd_addr   = 5'd0;
    bus.ex_rs2_addr   = 5'd0;
    #1 chk("fwd_b_x0", 32'(bus.forward_b), 32'd0);
    bus.mem_rd_addr   = 5'd9;
    bus.ex_rs2_addr   = 5'd9;
    #1 chk("fwd_b_mem", 32'(bus.forward_b), 32'd2);
    bus.ex_rs1_addr   = 5'd12;
    #1 chk("fwd_a_none", 32'(bus.forward_a), 32'd0);

    // Redirect with two fetch-latency bubbles; load-use masked meanwhile.
    @(negedge clk);
    idle();
    bus.ex_redirect = 1'b1;
    #1 chk("rd_accept", ctl(), 32'h0A);
    @(negedge clk);
    bus.ex_redirect = 1'b0;
    set_load_use(5'd5, 5'd5, 1'b1);
    #1 chk("rd_bub1", ctl(), 32'h08);
    chk("rd_flush_cnt", 32'(bus.flush_events), 32'd1);
    @(negedge clk);
    chk("rd_bub2", ctl(), 32'h08);
    @(negedge clk);
    idle();
    #1 chk("rd_done", ctl(), 32'h00);
    chk("rd_no_stall_cnt", 32'(bus.stall_cycles), 32'd2);

    // Memory wait holding a redirect for three cycles.
    @(negedge clk);
    bus.ex_redirect = 1'b1;
    bus.mem_req     = 1'b1;
    bus.mem_ready   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mw_stall", ctl(), 32'h35);
      @(negedge clk);
    end
    bus.mem_ready = 1'b1;
    #1 chk("mw_release", ctl(), 32'h0A);
    @(negedge clk);
    idle();
    #1 chk("mw_stall_cnt", 32'(bus.stall_cycles), 32'd5);
    chk("mw_flush_cnt", 32'(bus.flush_events), 32'd2);
    chk("mw_bub1", ctl(), 32'h08);
    @(negedge clk);
    chk("mw_bub2", ctl(), 32'h08);
    @(negedge clk);
    chk("mw_done", ctl(), 32'h00);

    // Twenty stall cycles: counter must stick at 15, never wrap.
    bus.mem_req = 1'b1;
    repeat (10) @(negedge clk);
    chk("sat_reach", 32'(bus.stall_cycles), 32'd15);
    repeat (10) @(negedge clk);
    idle();
    #1 chk("sat_hold", 32'(bus.stall_cycles), 32'd15);

    // Asynchronous reset in the middle of redirect bubbles.
    @(negedge clk);
    bus.ex_redirect = 1'b1;
    @(negedge clk);
    bus.ex_redirect = 1'b0;
    #1 chk("ar_in_redirect", ctl(), 32'h08);
    chk("ar_flush_pre", 32'(bus.flush_events), 32'd3);
    #1 rst = 1'b1;
    #1 chk("ar_ctl", ctl(), 32'h0A);
    chk("ar_stall_cnt", 32'(bus.stall_cycles), 32'd0);
    chk("ar_flush_cnt", 32'(bus.flush_events), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ar_run", ctl(), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
